// File: rtl/btn_cond_pkg.sv
// Shared types for the push-button step conditioner.
// Debounce state encoding and synchroniser depth.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/btn_debounce.sv
// Per-key synchroniser, debounce FSM and press pulse.
// level follows the accepted key state; press marks acceptance.
module btn_debounce
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic IDLE_LVL = BTN_ACTIVE_LOW;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pressed;
  db_state_t              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   press_d;

  // Synchroniser resets to the idle pin level so no false press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= {SYNC_STAGES{IDLE_LVL}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
  end

  assign pressed = sync_q[SYNC_STAGES-1] ^ IDLE_LVL;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press   <= press_d;
    end
  end

  assign level = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/btn_step_conditioner.sv
// Turns inc/dec keys plus an auto-step tick into step pulses.
// Presses win over ticks; simultaneous presses cancel.
module btn_step_conditioner
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_CYCLES     = 50_000_000,
  parameter bit AUTO_EN         = 1'b1,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic step,
  output logic dec,
  output logic dec_held,
  output logic tick
);

  localparam int TW = $clog2(TICK_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic          unused_inc_level;
  logic          press_inc, press_dec;
  logic          any_press, one_press;
  logic [TW-1:0] tcnt_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_inc (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_inc_raw),
    .level  (unused_inc_level),
    .press  (press_inc)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_dec (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_dec_raw),
    .level  (dec_held),
    .press  (press_dec)
  );

  assign any_press = press_inc | press_dec;
  assign one_press = press_inc ^ press_dec;
  assign tick      = AUTO_EN && (tcnt_q == TICK_LAST);

  // Any accepted press restarts the auto-step period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      tcnt_q <= '0;
    else if (any_press || !AUTO_EN || tick)
      tcnt_q <= '0;
    else
      tcnt_q <= tcnt_q + TW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step <= 1'b0;
      dec  <= 1'b0;
    end else if (one_press) begin
      step <= 1'b1;
      dec  <= press_dec;
    end else if (!any_press && tick) begin
      step <= 1'b1;
      dec  <= dec_held;
    end else begin
      step <= 1'b0;
      dec  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_step_conditioner.sv
// Bench: auto and manual instances against a run-length/modulo model.
// Directed test-plan scenarios followed by random key activity.
module tb_btn_step_conditioner;

  localparam int D = 4;
  localparam int T = 10;
  localparam bit [1:0] AUTO = 2'b01;

  logic clk;
  logic reset;
  logic inc_n, dec_n;
  logic inc_p, dec_p;
  logic a_step, a_dec, a_held, a_tick;
  logic m_step_o, m_dec_o, m_held, m_tick;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en;

  assign inc_p = ~inc_n;
  assign dec_p = ~dec_n;

  btn_step_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .TICK_CYCLES    (T),
    .AUTO_EN        (1'b1),
    .BTN_ACTIVE_LOW (1'b1)
  ) u_auto (
    .clk        (clk),
    .reset      (reset),
    .btn_inc_raw(inc_n),
    .btn_dec_raw(dec_n),
    .step       (a_step),
    .dec        (a_dec),
    .dec_held   (a_held),
    .tick       (a_tick)
  );

  btn_step_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .TICK_CYCLES    (T),
    .AUTO_EN        (1'b0),
    .BTN_ACTIVE_LOW (1'b0)
  ) u_man (
    .clk        (clk),
    .reset      (reset),
    .btn_inc_raw(inc_p),
    .btn_dec_raw(dec_p),
    .step       (m_step_o),
    .dec        (m_dec_o),
    .dec_held   (m_held),
    .tick       (m_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: key accepted after D+1 consecutive differing
  // synchronised samples; tick phase is (cycle - restart) mod T.
  bit h0[2], h1[2], lvl[2], prs[2];
  int run[2];
  bit m_step[2], m_dec[2];
  int base[2];
  int cyc = 0;
  bit pr[2];
  bit s, tk, one, any;

  function automatic bit exp_tick(input int i);
    return AUTO[i] && (((cyc - base[i]) % T) == T - 1);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        h0[b] = 0; h1[b] = 0; lvl[b] = 0; run[b] = 0; prs[b] = 0;
      end
      cyc++;
      for (int i = 0; i < 2; i++) begin
        m_step[i] = 0; m_dec[i] = 0; base[i] = cyc;
      end
    end else begin
      one = prs[0] ^ prs[1];
      any = prs[0] | prs[1];
      for (int i = 0; i < 2; i++) begin
        tk = exp_tick(i);
        m_step[i] = one || (!any && tk);
        m_dec[i]  = one ? prs[1] : (m_step[i] ? lvl[1] : 1'b0);
        if (any) base[i] = cyc + 1;
      end
      pr[0] = ~inc_n;
      pr[1] = ~dec_n;
      for (int b = 0; b < 2; b++) begin
        s = h1[b];
        h1[b] = h0[b];
        h0[b] = pr[b];
        prs[b] = 0;
        if (s != lvl[b]) begin
          run[b]++;
          if (run[b] == D + 1) begin
            lvl[b] = s;
            run[b] = 0;
            prs[b] = s;
          end
        end else begin
          run[b] = 0;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("auto_step", a_step, m_step[0]);
      check("auto_dec", a_dec, m_dec[0]);
      check("auto_held", a_held, lvl[1]);
      check("auto_tick", a_tick, exp_tick(0));
      check("man_step", m_step_o, m_step[1]);
      check("man_dec", m_dec_o, m_dec[1]);
      check("man_held", m_held, lvl[1]);
      check("man_tick", m_tick, exp_tick(1));
    end
  end

  // Edges from the first sampling edge until the manual step shows.
  task automatic man_latency(input string tag);
    int k;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (m_step_o === 1'b1) break;
      k++;
    end
    check(tag, k, 7);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int mode, len;

  initial begin
    inc_n = 1; dec_n = 1; reset = 0; chk_en = 0;
    @(posedge clk);
    #1 chk_en = 1;
    idle(2);
    reset = 1;
    idle(4);

    // reset with dec held, then held through release
    dec_n = 0;
    idle(12);
    @(posedge clk);
    #2 reset = 0;
    #1;
    check("rst_a_step", a_step, 0);
    check("rst_a_dec", a_dec, 0);
    check("rst_a_held", a_held, 0);
    check("rst_a_tick", a_tick, 0);
    check("rst_m_step", m_step_o, 0);
    check("rst_m_held", m_held, 0);
    @(negedge clk);
    reset = 1;
    man_latency("rst_lat");
    check("rst_dir", m_dec_o, 1);
    @(negedge clk);
    dec_n = 1;
    idle(20);

    // clean inc press, long hold, release
    inc_n = 0;
    man_latency("inc_lat");
    check("inc_dir", m_dec_o, 0);
    idle(50);
    inc_n = 1;
    idle(20);

    // bouncing dec then hold
    for (int i = 0; i < 3; i++) begin
      dec_n = 0; idle(2);
      dec_n = 1; idle(2);
    end
    dec_n = 0;
    man_latency("dec_lat");
    check("dec_dir", m_dec_o, 1);
    idle(20);
    dec_n = 1;
    idle(20);

    // idle auto steps, then held dec
    idle(35);
    dec_n = 0;
    idle(40);
    dec_n = 1;
    idle(20);

    // both keys together
    inc_n = 0; dec_n = 0;
    idle(25);
    inc_n = 1; dec_n = 1;
    idle(25);

    // inc press landing on a tick cycle
    for (int i = 0; i < 2 * T; i++) begin
      if (((cyc + 7 - base[0]) % T) == T - 1) break;
      @(negedge clk);
    end
    inc_n = 0;
    idle(15);
    inc_n = 1;
    idle(20);

    for (int it = 0; it < 80; it++) begin
      mode = $urandom_range(0, 5);
      len  = $urandom_range(1, 25);
      @(negedge clk);
      case (mode)
        0: begin inc_n = 0; idle(len); inc_n = 1; end
        1: begin dec_n = 0; idle(len); dec_n = 1; end
        2: begin
          inc_n = 0;
          idle($urandom_range(0, 3));
          dec_n = 0;
          idle(len);
          inc_n = 1; dec_n = 1;
        end
        3: begin
          if ($urandom_range(0, 1) == 1) inc_n = 0;
          else dec_n = 0;
          idle($urandom_range(1, 4));
          inc_n = 1; dec_n = 1;
        end
        4: idle(len);
        default: begin
          if ($urandom_range(0, 1) == 1) dec_n = 0;
          idle($urandom_range(0, 10));
          @(posedge clk);
          #($urandom_range(1, 8));
          reset = 0;
          idle($urandom_range(1, 3));
          reset = 1;
          idle(len);
          dec_n = 1;
        end
      endcase
      idle($urandom_range(0, 12));
    end

    idle(30);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
